// File: rtl/bz_ser_pkg.sv
// Shared types and sizing helpers for the multi-channel BZ serializer.
package bz_ser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Flits needed to carry the payload of one word (continue bit excluded).
  function automatic int nslice(input int nin, input int nflit);
    return (nin - 1 + nflit - 1) / nflit;
  endfunction

  // Position of the continue (wormhole) flag within an input word.
  function automatic int cont_bit(input int nin);
    return nin - 1;
  endfunction

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
  import bz_ser_pkg::*;
#(
  parameter int NCH = 4
)
(
  input  logic [NCH-1:0]        i_req,
  input  logic [idx_w(NCH)-1:0] i_ptr,
  input  logic                  i_en,
  output logic [NCH-1:0]        o_gnt,
  output logic [idx_w(NCH)-1:0] o_idx,
  output logic                  o_any
);

  localparam int PW = idx_w(NCH);

  // Walk the requesters starting at the pointer, wrapping once.
  always_comb begin : search
    int           j;
    logic [PW-1:0] w_j;
    o_gnt = {NCH{1'b0}};
    o_idx = {PW{1'b0}};
    o_any = 1'b0;
    j     = 0;
    w_j   = {PW{1'b0}};
    if (i_en) begin
      for (int k = 0; k < NCH; k++) begin
        j   = int'(i_ptr) + k;
        j   = (j >= NCH) ? (j - NCH) : j;
        w_j = PW'(j);
        if (!o_any && i_req[w_j]) begin
          o_any      = 1'b1;
          o_gnt[w_j] = 1'b1;
          o_idx      = w_j;
        end else begin
          o_any = o_any;
        end
      end
    end else begin
      o_any = 1'b0;
    end
  end

endmodule

// File: rtl/bz_multi_serializer.sv
// Multi-channel word-to-flit serializer with wormhole locking and round-robin
// arbitration. Define BZ_SER_PARITY_EN to append an even-parity bit per flit.
module bz_multi_serializer
  import bz_ser_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int NIN   = 42,
  parameter int NFLIT = 10
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_v,
  input  logic [NCH*NIN-1:0]   in_d,
  output logic [NCH-1:0]       in_a,
  input  logic                 is_full,
  output logic                 wrreq,
`ifdef BZ_SER_PARITY_EN
  output logic [NFLIT+1:0]     data_out
`else
  output logic [NFLIT:0]       data_out
`endif
);

  localparam int NSLICE = nslice(NIN, NFLIT);
  localparam int SW     = idx_w(NSLICE);
  localparam int PW     = idx_w(NCH);
  localparam int CB     = cont_bit(NIN);
  localparam int PADW   = NSLICE * NFLIT;
  localparam logic [SW-1:0] LAST = SW'(NSLICE - 1);

  ser_state_t      r_state, w_next;
  logic [NIN-2:0]  r_word;
  logic [SW-1:0]   r_slice;
  logic            r_lock;
  logic [PW-1:0]   r_grant, r_rr_ptr;
  logic [PW-1:0]   w_grant_inc, w_arb_ptr, w_arb_idx, w_sel;
  logic [NCH-1:0]  w_arb_gnt;
  logic            w_arb_en, w_arb_any, w_latch, w_ptr_upd, w_wr, w_last, w_tail;
  logic [NIN-1:0]  w_sel_word;
  logic [PADW-1:0] w_padded;
  logic [NFLIT-1:0] w_flit;

  assign w_last      = (r_slice == LAST);
  assign w_grant_inc = (r_grant == PW'(NCH - 1)) ? {PW{1'b0}} : r_grant + PW'(1);

  // Arbitrate from idle, or at the end of an unlocked word using the advanced pointer.
  assign w_arb_en  = reset && !r_lock &&
                     ((r_state == ST_IDLE) || ((r_state == ST_SEND) && !is_full && w_last));
  assign w_arb_ptr = (r_state == ST_SEND) ? w_grant_inc : r_rr_ptr;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req (in_v),
    .i_ptr (w_arb_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Next state, word acceptance and write strobe.
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_sel     = r_grant;
    w_ptr_upd = 1'b0;
    w_wr      = 1'b0;
    if (!reset) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_lock) begin
            w_latch = in_v[r_grant];
          end else begin
            w_sel   = w_arb_idx;
            w_latch = w_arb_any;
          end
          w_next = w_latch ? ST_SEND : ST_IDLE;
        end
        ST_SEND: begin
          if (is_full) begin
            w_next = ST_SEND;
          end else begin
            w_wr = 1'b1;
            if (!w_last) begin
              w_next = ST_SEND;
            end else if (r_lock) begin
              // Wormhole: stay on the same channel, no re-arbitration.
              w_latch = in_v[r_grant];
              w_next  = w_latch ? ST_SEND : ST_IDLE;
            end else begin
              w_ptr_upd = 1'b1;
              w_sel     = w_arb_idx;
              w_latch   = w_arb_any;
              w_next    = w_latch ? ST_SEND : ST_IDLE;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Select the word of the channel being accepted.
  always_comb begin
    w_sel_word = {NIN{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (w_sel == PW'(k)) begin
        w_sel_word = in_d[k*NIN +: NIN];
      end else begin
        w_sel_word = w_sel_word;
      end
    end
  end

  assign in_a  = !w_latch ? {NCH{1'b0}} :
                 (w_arb_en ? w_arb_gnt : (NCH'(1'b1) << r_grant));
  assign wrreq = w_wr;

  // Payload is zero-extended so the top slice pads above the payload MSB.
  assign w_padded = PADW'(r_word);

  // Pick the current slice, most significant first.
  always_comb begin
    w_flit = {NFLIT{1'b0}};
    for (int k = 0; k < NSLICE; k++) begin
      if (r_slice == SW'(k)) begin
        w_flit = w_padded[(NSLICE-1-k)*NFLIT +: NFLIT];
      end else begin
        w_flit = w_flit;
      end
    end
  end

  assign w_tail = w_last && !r_lock;

`ifdef BZ_SER_PARITY_EN
  function automatic logic even_parity(input logic [NFLIT:0] v);
    return ^v;
  endfunction

  assign data_out = (r_state == ST_SEND) ?
                    {even_parity({w_tail, w_flit}), w_tail, w_flit} : {(NFLIT+2){1'b0}};
`else
  assign data_out = (r_state == ST_SEND) ? {w_tail, w_flit} : {(NFLIT+1){1'b0}};
`endif

  // State, word register, slice counter, lock and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_word   <= {(NIN-1){1'b0}};
      r_slice  <= {SW{1'b0}};
      r_lock   <= 1'b0;
      r_grant  <= {PW{1'b0}};
      r_rr_ptr <= {PW{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_word  <= w_sel_word[NIN-2:0];
        r_lock  <= w_sel_word[CB];
        r_grant <= w_sel;
        r_slice <= {SW{1'b0}};
      end else if (w_wr) begin
        r_slice <= w_last ? {SW{1'b0}} : r_slice + SW'(1);
      end
      if (w_ptr_upd) begin
        r_rr_ptr <= w_grant_inc;
      end
    end
  end

endmodule

// File: tb/tb_bz_multi_serializer.sv
// Self-checking bench: queue-based sources, transaction-level flit model,
// directed scenarios with literal expectations plus a randomized phase.
`timescale 1ns/1ps
module tb_bz_multi_serializer;

  localparam int NCH    = 4;
  localparam int NIN    = 42;
  localparam int NFLIT  = 10;
  localparam int NSLICE = 5;
`ifdef BZ_SER_PARITY_EN
  localparam int OW = NFLIT + 2;
  localparam logic [OW-1:0] F000 = 12'h000, F401 = 12'h401, F001 = 12'h801;
  localparam logic [OW-1:0] F3FF = 12'h3FF, F2AA = 12'hAAA, F155 = 12'h955, F4F0 = 12'hCF0;
`else
  localparam int OW = NFLIT + 1;
  localparam logic [OW-1:0] F000 = 11'h000, F401 = 11'h401, F001 = 11'h001;
  localparam logic [OW-1:0] F3FF = 11'h3FF, F2AA = 11'h2AA, F155 = 11'h155, F4F0 = 11'h4F0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               is_full = 1'b0;
  logic [NCH-1:0]     in_v = '0;
  logic [NCH*NIN-1:0] in_d = '0;
  logic [NCH-1:0]     in_a;
  logic               wrreq;
  logic [OW-1:0]      data_out;

  always #5 clk = ~clk;

  bz_multi_serializer #(.NCH(NCH), .NIN(NIN), .NFLIT(NFLIT)) dut (
    .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .is_full(is_full), .wrreq(wrreq), .data_out(data_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [NIN-1:0] chq [NCH][$];
  logic [OW-1:0]  fq[$];
  int             m_cur = 0;
  int             m_rr  = 0;
  logic           m_lock = 1'b0;
  logic [OW-1:0]  obs_q[$];
  int             stamp_q[$];
  int             ack_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] mkflit(input logic tail, input logic [NFLIT-1:0] f);
    logic [NFLIT:0] v;
    v = {tail, f};
`ifdef BZ_SER_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  // Expected flits of one word: payload split MSB slice first, tail on last if no continue.
  task automatic push_word(input logic [NIN-1:0] w);
    logic [63:0] p;
    p = 64'(w[NIN-2:0]);
    for (int s = 0; s < NSLICE; s++)
      fq.push_back(mkflit((s == NSLICE-1) && !w[NIN-1], NFLIT'(p >> ((NSLICE-1-s)*NFLIT))));
  endtask

  function automatic bit busy();
    bit b;
    b = (fq.size() != 0);
    for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic step();
    logic [NCH-1:0] exp_a, acked;
    logic           exp_wr;
    logic [NIN-1:0] w;
    int             cand;
    for (int i = 0; i < NCH; i++) begin
      in_v[i] = (chq[i].size() != 0);
      in_d[i*NIN +: NIN] = (chq[i].size() != 0) ? chq[i][0] : '0;
    end
    @(negedge clk);
    exp_a = '0;
    cand  = -1;
    if (!reset) begin
      chk("wrreq_in_reset", 64'(wrreq), 64'd0);
      chk("in_a_in_reset", 64'(in_a), 64'd0);
      fq.delete();
      m_lock = 1'b0; m_rr = 0; m_cur = 0;
    end else begin
      exp_wr = (fq.size() != 0) && !is_full;
      chk("wrreq", 64'(wrreq), 64'(exp_wr));
      if (fq.size() != 0) chk("data_out", 64'(data_out), 64'(fq[0]));
      if (exp_wr) begin
        void'(fq.pop_front());
        if (fq.size() == 0 && !m_lock) m_rr = (m_cur + 1) % NCH;
      end
      if (fq.size() == 0) begin
        if (m_lock) begin
          if (in_v[2'(m_cur)]) cand = m_cur;
        end else begin
          for (int k = 0; k < NCH; k++)
            if (cand < 0 && in_v[2'((m_rr + k) % NCH)]) cand = (m_rr + k) % NCH;
        end
      end
      if (cand >= 0) begin
        exp_a  = 4'(1) << cand;
        w      = in_d[cand*NIN +: NIN];
        m_cur  = cand;
        m_lock = w[NIN-1];
        push_word(w);
      end
      chk("in_a", 64'(in_a), 64'(exp_a));
    end
    acked = in_a;
    if (wrreq) begin
      obs_q.push_back(data_out);
      stamp_q.push_back(cyc);
    end
    for (int i = 0; i < NCH; i++) if (acked[i]) ack_log.push_back(i);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) if (acked[i] && chq[i].size() != 0) void'(chq[i].pop_front());
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    if (busy()) begin
      total++; bad++;
      $display("FAIL drain: still busy after %0d cycles, required idle", budget);
    end
    step();
    step();
  endtask

  task automatic clear_logs();
    obs_q.delete(); stamp_q.delete(); ack_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int t2_ord[4]  = '{1, 1, 1, 2};

  initial begin
    // Reset state
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    chk("rst_wrreq", 64'(wrreq), 64'd0);
    chk("rst_in_a", 64'(in_a), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);

    // Single word on channel 0
    clear_logs();
    chq[0].push_back(42'h000_0000_0001);
    run_idle(50);
    chk("t1_nflits", 64'(obs_q.size()), 64'd5);
    chk("t1_nacks", 64'(ack_log.size()), 64'd1);
    if (obs_q.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("t1_flit", 64'(obs_q[i]), 64'(F000));
      chk("t1_tail_flit", 64'(obs_q[4]), 64'(F401));
    end

    // Three-word wormhole on channel 1 with channel 2 competing
    clear_logs();
    chq[1].push_back({1'b1, 41'h0AB_CDEF_0123});
    chq[1].push_back({1'b1, 41'h1FF_0000_FFFF});
    chq[1].push_back({1'b0, 41'h055_AA55_AA55});
    chq[2].push_back({1'b0, 41'h123_4567_89AB});
    run_idle(100);
    chk("t2_nflits", 64'(obs_q.size()), 64'd20);
    chk("t2_nacks", 64'(ack_log.size()), 64'd4);
    if (ack_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_grant", 64'(ack_log[i]), 64'(t2_ord[i]));
    if (obs_q.size() == 20) begin
      for (int i = 0; i < 20; i++)
        chk("t2_tail", 64'(obs_q[i][NFLIT]), 64'((i == 14) || (i == 19)));
      chk("t2_no_bubble", 64'(stamp_q[19] - stamp_q[0]), 64'd19);
    end

    // All channels continuously valid from a fresh pointer
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NCH; i++)
        chq[i].push_back({1'b0, 41'({$urandom(), $urandom()})});
    run_idle(100);
    chk("t3_nflits", 64'(obs_q.size()), 64'd40);
    chk("t3_nacks", 64'(ack_log.size()), 64'd8);
    if (ack_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_grant", 64'(ack_log[i]), 64'(exp_ord[i]));
    if (obs_q.size() == 40) chk("t3_no_bubble", 64'(stamp_q[39] - stamp_q[0]), 64'd39);

    // Backpressure during the second flit
    clear_logs();
    chq[0].push_back({1'b0, 1'b1, 10'h3FF, 10'h2AA, 10'h155, 10'h0F0});
    for (int n = 0; n < 10 && ack_log.size() == 0; n++) step();
    step();
    is_full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t4_full_nflits", 64'(obs_q.size()), 64'd1);
    end
    is_full = 1'b0;
    run_idle(50);
    chk("t4_nflits", 64'(obs_q.size()), 64'd5);
    if (obs_q.size() == 5) begin
      chk("t4_f0", 64'(obs_q[0]), 64'(F001));
      chk("t4_f1", 64'(obs_q[1]), 64'(F3FF));
      chk("t4_f2", 64'(obs_q[2]), 64'(F2AA));
      chk("t4_f3", 64'(obs_q[3]), 64'(F155));
      chk("t4_f4", 64'(obs_q[4]), 64'(F4F0));
    end

    // Reset in the middle of a packet
    chq[2].push_back({1'b0, 41'h0AB_CDEF_0123});
    step();
    step();
    step();
    do_reset();
    clear_logs();
    chq[3].push_back({1'b0, 41'h0F0_F0F0_F0F0});
    chq[0].push_back({1'b0, 41'h100_0000_0000});
    step();
    chk("t5_no_write_after_reset", 64'(obs_q.size()), 64'd0);
    run_idle(50);
    chk("t5_nflits", 64'(obs_q.size()), 64'd10);
    if (ack_log.size() != 0) chk("t5_first_grant", 64'(ack_log[0]), 64'd0);
    if (obs_q.size() != 0) chk("t5_first_flit", 64'(obs_q[0]), 64'(F001));

    // Randomized traffic with backpressure and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (chq[i].size() < 4 && $urandom_range(0, 7) == 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++)
            chq[i].push_back({(k != len - 1), 41'({$urandom(), $urandom()})});
        end
      end
      is_full = ($urandom_range(0, 4) == 0);
      reset   = ($urandom_range(0, 999) != 0);
      step();
    end
    reset   = 1'b1;
    is_full = 1'b0;
    run_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
